// File: rtl/bcd_conv_scheduler_pkg.sv
// bcd_pkg: constants, FSM encoding and digit helper shared by the BCD scheduler
// and its conversion engine.
package bcd_pkg;
   localparam logic [31:0] BCD_MAX = 32'd9999;
   localparam int DIGITS = 4;
   typedef logic [3:0] digit_t;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, STORE} state_t;
   function automatic digit_t add3(input digit_t n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction
endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// bcd_conv_scheduler_if: request/result bundle between display sources and the
// BCD scheduler.
interface bcd_conv_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int BIN_W  = 14,
   parameter int BCD_W  = 16
);
   logic [NUM_CH-1:0]       req;
   logic [NUM_CH*BIN_W-1:0] bin_in;
   logic [NUM_CH*BCD_W-1:0] bcd_out;
   logic [NUM_CH-1:0]       bcd_valid;
   logic [NUM_CH-1:0]       done;
   logic                    busy;
   modport master (output req, bin_in, input bcd_out, bcd_valid, done, busy);
   modport slave  (input req, bin_in, output bcd_out, bcd_valid, done, busy);
endinterface

// File: rtl/bin2bcd_seq_engine.sv
// bin2bcd_seq_engine: sequential double-dabble converter, one shift per cycle,
// with a start/done handshake.
module bin2bcd_seq_engine
   import bcd_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [BIN_W-1:0]      i_bin,
   output logic [DIGITS*4-1:0]   o_bcd,
   output logic                  o_done
);
   localparam int CW = $clog2(BIN_W);
   logic [DIGITS*4-1:0] r_bcd, w_adj;
   logic [BIN_W-1:0]    r_bin;
   logic [CW-1:0]       r_cnt;
   logic                r_run, r_done;
   always_comb begin
      w_adj = r_bcd;
      for (int d = 0; d < DIGITS; d++) w_adj[d*4 +: 4] = add3(r_bcd[d*4 +: 4]);
   end
   // The first iteration is folded into the load: adding 3 to a cleared
   // accumulator is a no-op, so only the shift remains.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_run  <= 1'b0;
         r_done <= 1'b0;
         r_cnt  <= '0;
         r_bcd  <= '0;
         r_bin  <= '0;
      end else begin
         r_done <= r_run && (r_cnt == CW'(1));
         if (r_run) begin
            {r_bcd, r_bin} <= {w_adj[DIGITS*4-2:0], r_bin, 1'b0};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_run <= 1'b0;
         end else if (i_start) begin
            {r_bcd, r_bin} <= {{(DIGITS*4-1){1'b0}}, i_bin, 1'b0};
            r_cnt <= CW'(BIN_W - 1);
            r_run <= 1'b1;
         end
      end
   end
   assign o_bcd  = r_bcd;
   assign o_done = r_done;
endmodule

// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin sharing of one sequential binary-to-BCD engine
// among NUM_CH display channels, holding the latest result per channel.
module bcd_conv_scheduler
   import bcd_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int BIN_W  = 14,
   parameter int BCD_W  = 16
) (
   input logic                 clk,
   input logic                 rst,
   bcd_conv_scheduler_if.slave bus
);
   localparam int CHW = $clog2(NUM_CH);
   state_t              r_state, w_state_nxt;
   logic [NUM_CH-1:0]   r_pend, r_valid, r_done, w_grant;
   logic [CHW-1:0]      r_rr, r_ch, w_sel;
   logic                w_found;
   logic [BIN_W-1:0]    r_bin, w_sel_val, w_sat_val;
   logic [BCD_W-1:0]    r_bcd [NUM_CH];
   logic [DIGITS*4-1:0] w_eng_bcd;
   logic                w_eng_start, w_eng_done;
   // Descending scan so the last hit is the first pending channel at or after r_rr.
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_rr;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (r_pend[(int'(r_rr) + k) % NUM_CH]) begin
            w_found = 1'b1;
            w_sel   = CHW'((int'(r_rr) + k) % NUM_CH);
         end
      end
   end
   assign w_sel_val = bus.bin_in[int'(w_sel)*BIN_W +: BIN_W];
   assign w_sat_val = (32'(w_sel_val) > BCD_MAX) ? BIN_W'(BCD_MAX) : w_sel_val;
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = '0;
      w_eng_start = 1'b0;
      case (r_state)
         IDLE: if (w_found) begin
            w_state_nxt    = LAUNCH;
            w_grant[w_sel] = 1'b1;
         end
         LAUNCH: begin
            w_eng_start = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: if (w_eng_done) w_state_nxt = STORE;
         default: w_state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_pend  <= '0;
         r_rr    <= '0;
         r_ch    <= '0;
         r_bin   <= '0;
         r_valid <= '0;
         r_done  <= '0;
         for (int i = 0; i < NUM_CH; i++) r_bcd[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= (r_pend & ~w_grant) | bus.req;
         r_done  <= '0;
         if (w_grant != '0) begin
            r_ch  <= w_sel;
            r_bin <= w_sat_val;
            r_rr  <= (w_sel == CHW'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;
         end
         if (r_state == STORE) begin
            r_bcd[r_ch]   <= BCD_W'(w_eng_bcd);
            r_valid[r_ch] <= 1'b1;
            r_done[r_ch]  <= 1'b1;
         end
      end
   end
   bin2bcd_seq_engine #(.BIN_W(BIN_W)) u_eng (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_eng_start),
      .i_bin   (r_bin),
      .o_bcd   (w_eng_bcd),
      .o_done  (w_eng_done)
   );
   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign bus.bcd_out[g*BCD_W +: BCD_W] = r_bcd[g];
   end
   assign bus.bcd_valid = r_valid;
   assign bus.done      = r_done;
   assign bus.busy      = (r_state != IDLE);
endmodule
